tx_sync_multi_fsm: RTL and testbench

//  Multi-lane GTX TX phase-alignment sequencer; generalises the single-lane TX sync FSM.

---
 rtl/tx_sync_pkg.sv | 31 +++
 rtl/tx_sync_tcnt.sv | 26 ++
 rtl/tx_sync_multi_fsm.sv | 133 +++++++++++++
 tb/tb_tx_sync_multi_fsm.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/tx_sync_pkg.sv
// Shared types for the multi-lane TX phase-alignment sequencer.
// State encoding and a debug helper that renders the state name.
package tx_sync_pkg;

  typedef enum logic [2:0] {
    IDLE              = 3'd0,
    ALIGN_RESET       = 3'd1,
    PHASE_ALIGN       = 3'd2,
    READY             = 3'd3,
    WAIT_B4_SET_PHASE = 3'd4
  } state_t;

  // Widest name is "Wait_B4_Set_Phase", 17 characters.
  localparam int STATENAME_W = 8 * 17;

  function automatic logic [STATENAME_W-1:0] state_name(
    input state_t s
  );
    logic [STATENAME_W-1:0] n;
    case (s)
      IDLE:              n = "Idle";
      ALIGN_RESET:       n = "Align_Reset";
      PHASE_ALIGN:       n = "Phase_Align";
      READY:             n = "Ready";
      WAIT_B4_SET_PHASE: n = "Wait_B4_Set_Phase";
      default:           n = "Unknown";
    endcase
    return n;
  endfunction

endpackage

// File: rtl/tx_sync_tcnt.sv
// Terminal-count counter: counts while enabled, clears when not.
// Holds at MAX so it can never wrap inside a state.
module tx_sync_tcnt #(
  parameter int MAX = 1,
  localparam int W  = $clog2(MAX + 1)
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  assign tc = (cnt == W'(MAX));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (!tc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tx_sync_multi_fsm.sv
// Multi-lane TX phase-alignment sequencer with lock gating,
// lane mask, on-demand re-sync and a saturating re-sync counter.
module tx_sync_multi_fsm
  import tx_sync_pkg::*;
#(
  parameter int N_LANES  = 4,
  parameter int ARST_CNT = 20,
  parameter int WAIT_CNT = 32,
  parameter int SYNC_CNT = 8192,
  parameter int RCNT_W   = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               PLL_LOCK,
  input  logic               RESYNC,
  input  logic [N_LANES-1:0] LANE_EN,
  output logic [N_LANES-1:0] TXDLYALIGNRESET,
  output logic [N_LANES-1:0] TXENPMAPHASEALIGN,
  output logic [N_LANES-1:0] TXPMASETPHASE,
  output logic               SYNC_DONE,
  output logic               BUSY,
  output logic [RCNT_W-1:0]  RESYNC_CNT
);

  localparam int AW = $clog2(ARST_CNT + 1);
  localparam int WW = $clog2(WAIT_CNT + 1);
  localparam int SW = $clog2(SYNC_CNT + 1);

  state_t state, nstate;

  logic          ar_tc, wt_tc, pa_tc;
  logic [AW-1:0] ar_cnt;
  logic [WW-1:0] wt_cnt;
  logic [SW-1:0] pa_cnt;

  logic               leave_idle;
  logic               ctl_dly, ctl_ena, ctl_set, ctl_busy;
  logic               do_resync;
  logic [N_LANES-1:0] mask, mask_nx;
  logic [N_LANES-1:0] dly_nx, ena_nx, set_nx;

  // Lock loss overrides every other transition out of a running state.
  always_comb begin
    nstate = state;
    if (state != IDLE && !PLL_LOCK) begin
      nstate = IDLE;
    end else begin
      case (state)
        IDLE:
          if (PLL_LOCK) nstate = ALIGN_RESET;
        ALIGN_RESET:
          if (ar_tc) nstate = WAIT_B4_SET_PHASE;
        WAIT_B4_SET_PHASE:
          if (wt_tc) nstate = PHASE_ALIGN;
        PHASE_ALIGN:
          if (pa_tc) nstate = READY;
        READY:
          if (RESYNC) nstate = IDLE;
        default:
          nstate = IDLE;
      endcase
    end
  end

  // Counters are driven from nstate so they read 1 on a state's first cycle.
  tx_sync_tcnt #(.MAX(ARST_CNT)) u_ar_cnt (
    .CLK (CLK),
    .RST (RST),
    .en  (nstate == ALIGN_RESET),
    .cnt (ar_cnt),
    .tc  (ar_tc)
  );

  tx_sync_tcnt #(.MAX(WAIT_CNT)) u_wt_cnt (
    .CLK (CLK),
    .RST (RST),
    .en  (nstate == WAIT_B4_SET_PHASE),
    .cnt (wt_cnt),
    .tc  (wt_tc)
  );

  tx_sync_tcnt #(.MAX(SYNC_CNT)) u_pa_cnt (
    .CLK (CLK),
    .RST (RST),
    .en  (nstate == PHASE_ALIGN),
    .cnt (pa_cnt),
    .tc  (pa_tc)
  );

  assign leave_idle = (state == IDLE) && (nstate == ALIGN_RESET);
  assign mask_nx    = leave_idle ? LANE_EN : mask;

  assign ctl_dly  = (nstate == ALIGN_RESET);
  assign ctl_set  = (nstate == PHASE_ALIGN);
  assign ctl_ena  = (nstate == WAIT_B4_SET_PHASE) ||
                    (nstate == PHASE_ALIGN) ||
                    (nstate == READY);
  assign ctl_busy = ctl_dly || ctl_set ||
                    (nstate == WAIT_B4_SET_PHASE);

  assign do_resync = (state == READY) && PLL_LOCK && RESYNC;

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    assign dly_nx[i] = ctl_dly & mask_nx[i];
    assign ena_nx[i] = ctl_ena & mask_nx[i];
    assign set_nx[i] = ctl_set & mask_nx[i];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state             <= IDLE;
      mask              <= '0;
      TXDLYALIGNRESET   <= '0;
      TXENPMAPHASEALIGN <= '0;
      TXPMASETPHASE     <= '0;
      SYNC_DONE         <= 1'b0;
      BUSY              <= 1'b0;
      RESYNC_CNT        <= '0;
    end else begin
      state             <= nstate;
      mask              <= mask_nx;
      TXDLYALIGNRESET   <= dly_nx;
      TXENPMAPHASEALIGN <= ena_nx;
      TXPMASETPHASE     <= set_nx;
      SYNC_DONE         <= (nstate == READY);
      BUSY              <= ctl_busy;
      if (do_resync && (RESYNC_CNT != '1)) begin
        RESYNC_CNT <= RESYNC_CNT + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tx_sync_multi_fsm.sv
// Scoreboard bench for tx_sync_multi_fsm with short sequence counts.
// Driver queues expected outputs per edge; a negedge monitor checks them.
module tb_tx_sync_multi_fsm;

  typedef struct packed {
    logic [3:0] dly;
    logic [3:0] ena;
    logic [3:0] set;
    logic       done;
    logic       busy;
    logic [1:0] rc;
  } obs_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       PLL_LOCK = 1'b0;
  logic       RESYNC = 1'b0;
  logic [3:0] LANE_EN = 4'h0;
  logic [3:0] TXDLYALIGNRESET;
  logic [3:0] TXENPMAPHASEALIGN;
  logic [3:0] TXPMASETPHASE;
  logic       SYNC_DONE;
  logic       BUSY;
  logic [1:0] RESYNC_CNT;

  obs_t exp_q[$];
  int   tag_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   scen = 0;

  always #5 CLK = ~CLK;

  tx_sync_multi_fsm #(
    .N_LANES  (4),
    .ARST_CNT (3),
    .WAIT_CNT (4),
    .SYNC_CNT (10),
    .RCNT_W   (2)
  ) dut (
    .CLK               (CLK),
    .RST               (RST),
    .PLL_LOCK          (PLL_LOCK),
    .RESYNC            (RESYNC),
    .LANE_EN           (LANE_EN),
    .TXDLYALIGNRESET   (TXDLYALIGNRESET),
    .TXENPMAPHASEALIGN (TXENPMAPHASEALIGN),
    .TXPMASETPHASE     (TXPMASETPHASE),
    .SYNC_DONE         (SYNC_DONE),
    .BUSY              (BUSY),
    .RESYNC_CNT        (RESYNC_CNT)
  );

  function automatic obs_t actual();
    return {TXDLYALIGNRESET, TXENPMAPHASEALIGN, TXPMASETPHASE,
            SYNC_DONE, BUSY, RESYNC_CNT};
  endfunction

  // Expected outputs k edges after leaving Idle (k=0 means Idle).
  function automatic obs_t exp_at(input int k, input logic [3:0] m,
                                  input logic [1:0] rc);
    obs_t e;
    e = '0;
    e.rc = rc;
    if (k >= 1 && k <= 3) begin
      e.dly = m; e.busy = 1'b1;
    end else if (k >= 4 && k <= 7) begin
      e.ena = m; e.busy = 1'b1;
    end else if (k >= 8 && k <= 17) begin
      e.ena = m; e.set = m; e.busy = 1'b1;
    end else if (k >= 18) begin
      e.ena = m; e.done = 1'b1;
    end
    return e;
  endfunction

  task automatic check(input string name, input int tag,
                       input obs_t a, input obs_t e);
    n_checks++;
    if (a === e) begin
      n_pass++;
    end else begin
      $display("FAIL %s tag=%0d got dly=%h ena=%h set=%h done=%b busy=%b rc=%0d want dly=%h ena=%h set=%h done=%b busy=%b rc=%0d",
               name, tag, a.dly, a.ena, a.set, a.done, a.busy, a.rc,
               e.dly, e.ena, e.set, e.done, e.busy, e.rc);
    end
  endtask

  always @(negedge CLK) begin
    if (exp_q.size() != 0) begin
      obs_t e;
      int   t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check("cycle", t, actual(), e);
    end
  end

  task automatic step(input obs_t e, input int k);
    @(posedge CLK);
    exp_q.push_back(e);
    tag_q.push_back(scen * 100 + k);
    #1;
  endtask

  task automatic run(input logic [3:0] m, input logic [1:0] rc,
                     input int a, input int b);
    for (int k = a; k <= b; k++) step(exp_at(k, m, rc), k);
  endtask

  task automatic resync_pass(input logic [1:0] rc_after);
    RESYNC = 1'b1;
    step(exp_at(0, 4'h0, rc_after), 0);
    RESYNC = 1'b0;
    run(LANE_EN, rc_after, 1, 18);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog tag=0 got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2 RST = 1'b1;
    #1 check("reset", 0, actual(), '0);
    step('0, 0);
    step('0, 0);
    RST = 1'b0;
    step('0, 0);

    // 1: normal sequence, then linger in Ready
    scen = 1;
    LANE_EN = 4'hF;
    PLL_LOCK = 1'b1;
    run(4'hF, 2'd0, 1, 20);

    // 5b: RESYNC with lock loss in the same Ready cycle
    scen = 2;
    RESYNC = 1'b1;
    PLL_LOCK = 1'b0;
    step(exp_at(0, 4'h0, 2'd0), 0);
    RESYNC = 1'b0;
    step(exp_at(0, 4'h0, 2'd0), 0);
    PLL_LOCK = 1'b1;
    run(4'hF, 2'd0, 1, 18);

    // 3: lock loss in Phase_Align cycle 2, then full rerun
    scen = 3;
    RESYNC = 1'b1;
    PLL_LOCK = 1'b0;
    step(exp_at(0, 4'h0, 2'd0), 0);
    RESYNC = 1'b0;
    PLL_LOCK = 1'b1;
    run(4'hF, 2'd0, 1, 9);
    PLL_LOCK = 1'b0;
    step(exp_at(0, 4'h0, 2'd0), 0);
    step(exp_at(0, 4'h0, 2'd0), 0);
    PLL_LOCK = 1'b1;
    run(4'hF, 2'd0, 1, 18);

    // 4: re-sync with a RESYNC pulse during Align_Reset
    scen = 4;
    RESYNC = 1'b1;
    step(exp_at(0, 4'h0, 2'd1), 0);
    RESYNC = 1'b0;
    run(4'hF, 2'd1, 1, 1);
    RESYNC = 1'b1;
    run(4'hF, 2'd1, 2, 2);
    RESYNC = 1'b0;
    run(4'hF, 2'd1, 3, 18);

    // 2: masked lanes, mask change mid-sequence ignored
    scen = 5;
    LANE_EN = 4'b0101;
    RESYNC = 1'b1;
    step(exp_at(0, 4'h0, 2'd2), 0);
    RESYNC = 1'b0;
    run(4'b0101, 2'd2, 1, 5);
    LANE_EN = 4'hF;
    run(4'b0101, 2'd2, 6, 19);

    // 5: saturation of the 2-bit counter
    scen = 6;
    resync_pass(2'd3);
    scen = 7;
    resync_pass(2'd3);
    scen = 8;
    resync_pass(2'd3);

    // All-zero mask still reaches Ready
    scen = 9;
    LANE_EN = 4'h0;
    resync_pass(2'd3);
    LANE_EN = 4'hF;

    // 6: async reset between edges in Wait_B4_Set_Phase
    scen = 10;
    resync_pass(2'd3);
    RESYNC = 1'b1;
    step(exp_at(0, 4'h0, 2'd3), 0);
    RESYNC = 1'b0;
    run(4'hF, 2'd3, 1, 5);
    @(negedge CLK);
    #1 RST = 1'b1;
    #1 check("async_rst", 1000, actual(), '0);
    step('0, 0);
    RST = 1'b0;
    run(4'hF, 2'd0, 1, 18);

    @(negedge CLK);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain tag=0 got %0d left want 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
